mux_sel_pipe: RTL and testbench

MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_comb_n.sv | 21 ++
 rtl/mux_sel_pipe.sv | 118 +++++++++++
 tb/tb_mux_sel_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared skid-buffer state encoding and default sizing for mux_sel_pipe
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_NUM_IN = 5;

endpackage

// File: rtl/mux_comb_n.sv
// rtl/mux_comb_n.sv - combinational N-way word select; out-of-range select yields zero
module mux_comb_n #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data
);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_flat[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// rtl/mux_sel_pipe.sv - registered word select behind a 2-entry skid buffer
// Define MUX_SEL_PIPE_ERR_EN to get a sticky out-of-range select flag on err.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]        S,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        O,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             emit;

  mux_comb_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_flat  (I),
    .sel      (S),
    .sel_data (sel_data)
  );

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // out_data always holds the oldest word; skid only fills when output is occupied and stalled
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          out_data_d = sel_data;
        end
      end
      ONE: begin
        if (accept && emit) begin
          out_data_d = sel_data;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = sel_data;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = in_ready_q;
    O         = out_data_q;
  end

`ifdef MUX_SEL_PIPE_ERR_EN
  localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W+1)'(NUM_IN);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (accept & ({1'b0, S} >= NUM_IN_EXT));
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb/tb_mux_sel_pipe.sv - directed self-checking bench for mux_sel_pipe (default 16x5)
module tb_mux_sel_pipe;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  logic                    CLK;
  logic                    Reset;
  logic [NUM_IN*WIDTH-1:0] I;
  logic [SEL_W-1:0]        S;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        O;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] words [NUM_IN];
  logic             exp_err;

  mux_sel_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .I         (I),
    .S         (S),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .O         (O),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [SEL_W-1:0] sel);
    S        = sel;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef MUX_SEL_PIPE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'hBEEF;
    words[4] = 16'h4444;
    for (int k = 0; k < NUM_IN; k++) I[k*WIDTH +: WIDTH] = words[k];
    S         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Reset     = 1'b1;

    cyc();
    cyc();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_O",         32'(O),         32'h0000);
    check("rst_err",       32'(err),       32'd0);
    Reset = 1'b0;
    cyc();

    // single pass through S=3
    out_ready = 1'b1;
    push(3'd3);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_O",         32'(O),         32'hBEEF);
    cyc();
    check("single_drain_valid", 32'(out_valid), 32'd0);
    check("single_in_ready",    32'(in_ready),  32'd1);

    // backpressure fills the skid, then drains in order
    out_ready = 1'b0;
    push(3'd0);
    check("bp_one_valid", 32'(out_valid), 32'd1);
    check("bp_one_O",     32'(O),         32'h1111);
    check("bp_one_ready", 32'(in_ready),  32'd1);
    push(3'd4);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_O",     32'(O),        32'h1111);
    push(3'd1);
    check("bp_ignored_O",     32'(O),         32'h1111);
    check("bp_ignored_valid", 32'(out_valid), 32'd1);
    check("bp_ignored_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    cyc();
    check("bp_drain1_O",     32'(O),         32'h4444);
    check("bp_drain1_valid", 32'(out_valid), 32'd1);
    check("bp_drain1_ready", 32'(in_ready),  32'd1);
    cyc();
    check("bp_drain2_valid", 32'(out_valid), 32'd0);

    // full-rate streaming S=0..4
    for (int s = 0; s < NUM_IN; s++) begin
      S        = SEL_W'(s);
      in_valid = 1'b1;
      cyc();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_O",     32'(O),         32'(words[s]));
      check("stream_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_end_valid", 32'(out_valid), 32'd0);

    // out-of-range select captures zero
    push(3'd6);
    check("oor_valid", 32'(out_valid), 32'd1);
    check("oor_O",     32'(O),         32'h0000);
    check("oor_err",   32'(err),       32'(exp_err));
    push(3'd1);
    check("oor_next_O",   32'(O),   32'h2222);
    check("oor_err_hold", 32'(err), 32'(exp_err));
    cyc();
    check("oor_err_sticky", 32'(err), 32'(exp_err));

    // reset while FULL overrides accept and emit
    out_ready = 1'b0;
    push(3'd2);
    push(3'd3);
    check("mid_full_ready", 32'(in_ready), 32'd0);
    check("mid_full_O",     32'(O),        32'h3333);
    Reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    S         = 3'd0;
    cyc();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_O",     32'(O),         32'h0000);
    check("mid_rst_err",   32'(err),       32'd0);
    Reset    = 1'b0;
    in_valid = 1'b0;
    cyc();
    check("mid_after_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
